// File: rtl/uartrx_frame_ctrl.sv
// uartrx_frame_ctrl: UART receive framing FSM that drives the stop-bit checker and publishes accepted bytes
module uartrx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 framing_error,
    output logic                 sbc_clear,
    output logic                 sbc_enable,
    output logic                 stop_bit,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_valid
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BLAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, SBC, CHK} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [3:0] bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic prev_line, start_edge, sample, clear_nx, enable_nx, valid_nx;

    assign start_edge = prev_line & ~serial_in;

    // Next state, bit-sample strobe and next values of the registered pulse outputs
    always_comb begin
        state_nx  = state;
        sample    = 1'b0;
        clear_nx  = (state == IDLE) && start_edge;
        enable_nx = (state == STOP) && (cnt == LAST);
        valid_nx  = (state == CHK) && !framing_error;
        case (state)
            IDLE:  state_nx = start_edge ? START : IDLE;
            START: if (cnt == HALF) begin
                sample   = 1'b1;
                state_nx = serial_in ? IDLE : DATA;
            end
            DATA:  if (cnt == LAST) begin
                sample   = 1'b1;
                state_nx = (bit_idx == BLAST) ? STOP : DATA;
            end
            STOP:  if (cnt == LAST) begin
                sample   = 1'b1;
                state_nx = SBC;
            end
            SBC:     state_nx = CHK;
            CHK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    // Oversample counter, shifter, stop sample and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            prev_line  <= 1'b1;
            stop_bit   <= 1'b1;
            rx_data    <= '0;
            sbc_clear  <= 1'b0;
            sbc_enable <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            prev_line  <= serial_in;
            cnt        <= (state == IDLE || sample || state_nx != state) ? '0 : cnt + 1'b1;
            sbc_clear  <= clear_nx;
            sbc_enable <= enable_nx;
            data_valid <= valid_nx;
            if (state == START && sample)
                bit_idx <= '0;
            if (state == DATA && sample) begin
                shreg   <= {serial_in, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == STOP && sample)
                stop_bit <= serial_in;
            if (valid_nx)
                rx_data <= shreg;
        end
    end
endmodule

// File: tb/tb_uartrx_frame_ctrl.sv
// tb_uartrx_frame_ctrl: directed and random frames checked against a frame-level timing/data model
module tb_uartrx_frame_ctrl;
    localparam int CPB = 10;
    localparam int DB  = 8;
    localparam int T_EN = 1 + CPB / 2 + CPB * (DB + 1);

    logic clk = 1'b0, rst = 1'b1, serial_in = 1'b1, framing_error = 1'b0;
    logic sbc_clear, sbc_enable, stop_bit, data_valid;
    logic [DB-1:0] rx_data;
    int cyc = 0, checks = 0, failures = 0;
    int n_clr = 0, n_en = 0, n_dv = 0, n_both = 0, clr_cyc = 0, en_cyc = 0, dv_cyc = 0;
    logic en_stop = 1'b0;
    logic [DB-1:0] dv_data = '0, exp_rx = '0;

    uartrx_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .framing_error(framing_error),
        .sbc_clear(sbc_clear), .sbc_enable(sbc_enable), .stop_bit(stop_bit),
        .rx_data(rx_data), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp observed pulses
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in stop-bit checker: registered error flag, cleared at frame start
    always @(posedge clk) begin
        if (rst || sbc_clear) framing_error <= 1'b0;
        else if (sbc_enable) framing_error <= ~stop_bit;
    end

    // Pulse monitor sampling away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (sbc_clear) begin n_clr++; clr_cyc = cyc; end
            if (sbc_enable) begin n_en++; en_cyc = cyc; en_stop = stop_bit; end
            if (data_valid) begin n_dv++; dv_cyc = cyc; dv_data = rx_data; end
            if (sbc_clear && sbc_enable) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        serial_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DB-1:0] d, input logic stp, input int gap);
        int c0, b_clr, b_en, b_dv;
        b_clr = n_clr; b_en = n_en; b_dv = n_dv; c0 = cyc;
        drive(1'b0, CPB);
        for (int i = 0; i < DB; i++) drive(d[i], CPB);
        drive(stp, CPB);
        if (stp) exp_rx = d;
        chk("clr_cnt", n_clr - b_clr, 1);
        chk("clr_time", clr_cyc, c0 + 1);
        chk("en_cnt", n_en - b_en, 1);
        chk("en_time", en_cyc, c0 + T_EN);
        chk("stop_bit", {31'd0, en_stop}, {31'd0, stp});
        chk("dv_cnt", n_dv - b_dv, {31'd0, stp});
        if (stp) begin
            chk("dv_time", dv_cyc, c0 + T_EN + 2);
            chk("dv_data", {24'd0, dv_data}, {24'd0, d});
        end
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx});
        if (gap > 0) drive(1'b1, gap);
    endtask

    initial begin
        int b_clr, b_en, b_dv, c0, gap;
        logic [DB-1:0] d, v5;
        logic stp;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clear", {31'd0, sbc_clear}, 0);
        chk("rst_enable", {31'd0, sbc_enable}, 0);
        chk("rst_valid", {31'd0, data_valid}, 0);
        chk("rst_stop", {31'd0, stop_bit}, 1);
        chk("rst_rx", {24'd0, rx_data}, 0);
        rst = 1'b0;
        drive(1'b1, CPB);
        send(8'hA5, 1'b1, CPB);
        send(8'h3C, 1'b0, 2);
        b_clr = n_clr; b_en = n_en; b_dv = n_dv; c0 = cyc;
        drive(1'b0, 3);
        drive(1'b1, 2 * CPB);
        chk("glitch_clr", n_clr - b_clr, 1);
        chk("glitch_clr_time", clr_cyc, c0 + 1);
        chk("glitch_en", n_en - b_en, 0);
        chk("glitch_dv", n_dv - b_dv, 0);
        chk("glitch_rx", {24'd0, rx_data}, {24'd0, exp_rx});
        send(8'h00, 1'b1, 0);
        send(8'hFF, 1'b1, CPB);
        v5 = 8'h5A;
        drive(1'b0, CPB);
        for (int i = 0; i < 3; i++) drive(v5[i], CPB);
        serial_in = v5[3];
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_clear", {31'd0, sbc_clear}, 0);
        chk("mid_rst_enable", {31'd0, sbc_enable}, 0);
        chk("mid_rst_valid", {31'd0, data_valid}, 0);
        chk("mid_rst_stop", {31'd0, stop_bit}, 1);
        chk("mid_rst_rx", {24'd0, rx_data}, 0);
        exp_rx = '0;
        rst = 1'b0;
        b_en = n_en; b_dv = n_dv;
        drive(1'b1, 6 * CPB);
        chk("abort_en", n_en - b_en, 0);
        chk("abort_dv", n_dv - b_dv, 0);
        send(8'h81, 1'b1, CPB);
        send(8'h3C, 1'b0, 0);
        b_clr = n_clr;
        drive(1'b0, 30);
        chk("break_clr", n_clr - b_clr, 0);
        drive(1'b1, CPB);
        send(8'h42, 1'b1, CPB);
        for (int k = 0; k < 10; k++) begin
            d = DB'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            gap = stp ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 4));
            send(d, stp, gap);
        end
        drive(1'b1, 2 * CPB);
        chk("clr_en_overlap", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
